instr_mem_responder: RTL and testbench
======================================

// Module: instr_mem_responder
// PURPOSE
//  Responder side of the core's instruction-fetch interface: a 32x16 program store that answers
//  fetch requests (address = core PC) after a programmable number of wait states.
//  A separate load port writes programs before or between runs; it sits beside cpu_core in the top.
//  Provides the fetch path that cpu_core initiates, with realistic memory latency for bench stress.
// PARAMETERS
//  ADDR_W       5    fetch/load address width; DEPTH = 2**ADDR_W words
//  DATA_W       16   instruction word width
//  WAIT_CYCLES  1    wait states inserted before response, legal range 0..7
// PORTS
//  clock        in   1       single clock, all logic on rising edge
//  reset        in   1       synchronous, active-high
//  fetch_req    in   1       fetch request; sampled only in IDLE
//  fetch_addr   in   ADDR_W  word address (PC), captured with fetch_req
//  fetch_valid  out  1       one-cycle pulse: fetch_data holds the requested word
//  fetch_data   out  DATA_W  response word; holds last delivered value between pulses
//  busy         out  1       high in WAIT and RESP
//  load_en      in   1       write strobe for the program store
//  load_addr    in   ADDR_W  write address
//  load_data    in   DATA_W  write data
//  load_err     out  1       sticky: load_en seen while busy; cleared only by reset
//  fetch_count  out  16      completed fetches (only with INSTR_MEM_FETCH_COUNT_EN)
// BEHAVIOUR
//  - Reset: fetch_valid=0, fetch_data=0, busy=0, load_err=0, fetch_count=0, state=IDLE.
//    Storage array is NOT cleared by reset; contents survive reset.
//  - FSM IDLE/WAIT/RESP. IDLE & fetch_req: capture addr; -> WAIT with ctr=WAIT_CYCLES-1,
//    or -> RESP directly if WAIT_CYCLES==0. WAIT: ctr decrements; at ctr==0 -> RESP.
//    RESP: fetch_valid=1, fetch_data=mem[captured addr]; -> IDLE unconditionally.
//  - Latency: fetch_valid asserts exactly WAIT_CYCLES+1 cycles after the sampling edge.
//    Min request period WAIT_CYCLES+2; fetch_req held high re-issues on each IDLE cycle.
//  - fetch_req in WAIT/RESP ignored (not queued). fetch_addr changes after capture ignored.
//  - Load in IDLE: mem[load_addr]<=load_data at the edge. Load in WAIT/RESP: write dropped,
//    load_err<=1. Same-edge load and fetch_req in IDLE, same address: write happens; the
//    fetch returns the NEW data (array read occurs in RESP, after the write).
//  - Address is exactly ADDR_W bits: address 31 is valid, no wrap or out-of-range case.
//  - Reset during WAIT/RESP: next cycle IDLE, no fetch_valid pulse for the aborted fetch.
// CONFIGURATION
//  INSTR_MEM_FETCH_COUNT_EN defined: fetch_count port present; +1 on every fetch_valid,
//    saturates at 16'hFFFF, reset to 0. Undefined: port and counter absent, rest identical.
// STRUCTURE
//  Package instr_mem_pkg: fetch_state_t enum {IDLE,WAIT,RESP}; default ADDR_W/DATA_W
//    constants; MAX_WAIT=7 constant.
//  Sub-module instr_mem_array: DEPTH x DATA_W storage with one write port and one
//    combinational read port; FSM, wait counter, and error/count logic stay in the top.
// TESTING
//  1 Load addr0..3 = 16'h1234,16'hABCD,16'h0F0F,16'h8001; fetch addr2 (WAIT=1) ->
//    fetch_valid pulses 2 cycles after sampling, fetch_data=16'h0F0F, busy high 2 cycles.
//  2 fetch_req held high, fetch_addr 0 then 1 -> valid pulses 3 cycles apart,
//    data 16'h1234 then 16'hABCD; no extra or lost pulses.
//  3 load_en addr1=16'hFFFF during WAIT -> load_err=1 and stays 1; later fetch of addr1
//    still returns 16'hABCD.
//  4 Same edge in IDLE: load addr5=16'h00FF + fetch addr5 -> response 16'h00FF.
//  5 Reset asserted in WAIT -> next cycle busy=0, no valid pulse, load_err=0;
//    fetch addr0 afterwards returns 16'h1234 (contents preserved).
//  6 WAIT_CYCLES=0 build, load addr31=16'h7777, fetch 31 -> valid next cycle, 16'h7777;
//    with INSTR_MEM_FETCH_COUNT_EN, three fetches -> fetch_count=3.

Source files
------------

// File: rtl/instr_mem_responder_pkg.sv
// rtl/instr_mem_responder_pkg.sv - shared types and constants for the instruction memory responder
package instr_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } fetch_state_t;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 16;
    localparam int MAX_WAIT   = 7;
    localparam int CTR_W      = 3;

endpackage

// File: rtl/instr_mem_responder_if.sv
// rtl/instr_mem_responder_if.sv - fetch and program-load signal bundle
interface instr_mem_responder_if
    import instr_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              busy;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_err;

    modport master (
        output fetch_req, fetch_addr, load_en, load_addr, load_data,
        input  fetch_valid, fetch_data, busy, load_err
    );

    modport slave (
        input  fetch_req, fetch_addr, load_en, load_addr, load_data,
        output fetch_valid, fetch_data, busy, load_err
    );
endinterface

// File: rtl/instr_mem_responder_array.sv
// rtl/instr_mem_responder_array.sv - program store, one write port and one combinational read port
module instr_mem_array
    import instr_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_clock,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    // No reset on purpose: a loaded program must survive a core reset.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - fetch responder with programmable wait states
// Optional fetch counter enabled by INSTR_MEM_FETCH_COUNT_EN.
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    instr_mem_responder_if.slave  bus
`ifdef INSTR_MEM_FETCH_COUNT_EN
    ,
    output logic [15:0]           fetch_count
`endif
);
    localparam logic [CTR_W-1:0] WAIT_INIT =
        (WAIT_CYCLES == 0) ? '0 : CTR_W'(WAIT_CYCLES - 1);

    fetch_state_t      r_state;
    logic [CTR_W-1:0]  r_ctr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_err;
    logic              w_we;
    logic [DATA_W-1:0] w_rd_data;

    // Loads are only honoured while no fetch is in flight.
    assign w_we = bus.load_en && (r_state == IDLE) && !reset;

    instr_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .i_clock (clock),
        .i_we    (w_we),
        .i_waddr (bus.load_addr),
        .i_wdata (bus.load_data),
        .i_raddr (r_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_ctr   <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (bus.load_en && (r_state != IDLE)) begin
                r_err <= 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (bus.fetch_req) begin
                        r_addr <= bus.fetch_addr;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= WAIT;
                            r_ctr   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_ctr == '0) begin
                        r_state <= RESP;
                    end else begin
                        r_ctr <= r_ctr - 1'b1;
                    end
                end
                RESP: begin
                    // Array is read here, so a same-edge load in IDLE is already visible.
                    r_valid <= 1'b1;
                    r_data  <= w_rd_data;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.fetch_valid = r_valid;
    assign bus.fetch_data  = r_data;
    assign bus.busy        = (r_state != IDLE);
    assign bus.load_err    = r_err;

`ifdef INSTR_MEM_FETCH_COUNT_EN
    logic [15:0] r_fetch_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_count <= '0;
        end else if ((r_state == RESP) && (r_fetch_count != 16'hFFFF)) begin
            r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb/tb_instr_mem_responder.sv - self-checking bench for instr_mem_responder (WAIT=1 and WAIT=0 instances)
module tb_instr_mem_responder;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    typedef struct {
        bit          is_load;
        logic [4:0]  addr;
        logic [15:0] data;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q1[$];
    exp_t q0[$];
    exp_t e1;
    exp_t e0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    instr_mem_responder_if #(.ADDR_W(5), .DATA_W(16)) bus1 ();
    instr_mem_responder_if #(.ADDR_W(5), .DATA_W(16)) bus0 ();

`ifdef INSTR_MEM_FETCH_COUNT_EN
    logic [15:0] cnt1;
    logic [15:0] cnt0;
`endif

    instr_mem_responder #(.ADDR_W(5), .DATA_W(16), .WAIT_CYCLES(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
`ifdef INSTR_MEM_FETCH_COUNT_EN
        ,
        .fetch_count (cnt1)
`endif
    );

    instr_mem_responder #(.ADDR_W(5), .DATA_W(16), .WAIT_CYCLES(0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
`ifdef INSTR_MEM_FETCH_COUNT_EN
        ,
        .fetch_count (cnt0)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clock) begin
        if (bus1.fetch_valid) begin
            if (q1.size() == 0) begin
                chk("w1_unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("w1_data", 32'(bus1.fetch_data), 32'(e1.data));
                chk("w1_latency", 32'(cyc), 32'(e1.due));
            end
        end
    end

    always @(negedge clock) begin
        if (bus0.fetch_valid) begin
            if (q0.size() == 0) begin
                chk("w0_unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                chk("w0_data", 32'(bus0.fetch_data), 32'(e0.data));
                chk("w0_latency", 32'(cyc), 32'(e0.due));
            end
        end
    end

    task automatic do_load(input bit w0, input logic [4:0] a, input logic [15:0] d);
        @(negedge clock);
        if (w0) begin
            bus0.load_en = 1'b1; bus0.load_addr = a; bus0.load_data = d;
        end else begin
            bus1.load_en = 1'b1; bus1.load_addr = a; bus1.load_data = d;
        end
        @(negedge clock);
        bus0.load_en = 1'b0;
        bus1.load_en = 1'b0;
    endtask

    task automatic do_fetch(input bit w0, input logic [4:0] a, input logic [15:0] d);
        exp_t e;
        @(negedge clock);
        e.data = d;
        e.due  = cyc + 2 + (w0 ? 0 : 1);
        if (w0) begin
            bus0.fetch_req = 1'b1; bus0.fetch_addr = a; q0.push_back(e);
        end else begin
            bus1.fetch_req = 1'b1; bus1.fetch_addr = a; q1.push_back(e);
        end
        @(negedge clock);
        bus0.fetch_req = 1'b0;
        bus1.fetch_req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (((q0.size() + q1.size()) != 0) && (n < 20)) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk("drain_pending", 32'(q0.size() + q1.size()), 32'd0);
        q0.delete();
        q1.delete();
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        exp_t e;
        int   base;

        vecs[0] = '{1'b1, 5'd0,  16'h1234};
        vecs[1] = '{1'b1, 5'd1,  16'hABCD};
        vecs[2] = '{1'b1, 5'd2,  16'h0F0F};
        vecs[3] = '{1'b1, 5'd3,  16'h8001};
        vecs[4] = '{1'b1, 5'd31, 16'h5A5A};
        vecs[5] = '{1'b0, 5'd2,  16'h0F0F};
        vecs[6] = '{1'b0, 5'd0,  16'h1234};
        vecs[7] = '{1'b0, 5'd3,  16'h8001};
        vecs[8] = '{1'b0, 5'd31, 16'h5A5A};
        vecs[9] = '{1'b0, 5'd1,  16'hABCD};

        bus1.fetch_req = 1'b0; bus1.fetch_addr = '0;
        bus1.load_en = 1'b0; bus1.load_addr = '0; bus1.load_data = '0;
        bus0.fetch_req = 1'b0; bus0.fetch_addr = '0;
        bus0.load_en = 1'b0; bus0.load_addr = '0; bus0.load_data = '0;

        repeat (3) @(negedge clock);
        chk("rst_valid", 32'(bus1.fetch_valid), 32'd0);
        chk("rst_data", 32'(bus1.fetch_data), 32'd0);
        chk("rst_busy", 32'(bus1.busy), 32'd0);
        chk("rst_err", 32'(bus1.load_err), 32'd0);
        chk("rst_busy_w0", 32'(bus0.busy), 32'd0);
`ifdef INSTR_MEM_FETCH_COUNT_EN
        chk("rst_count", 32'(cnt1), 32'd0);
`endif
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_load) begin
                do_load(1'b0, vecs[i].addr, vecs[i].data);
            end else begin
                do_fetch(1'b0, vecs[i].addr, vecs[i].data);
                drain();
            end
        end
        chk("err_after_idle_loads", 32'(bus1.load_err), 32'd0);

        // Basic latency and busy window.
        @(negedge clock);
        e.data = 16'h0F0F; e.due = cyc + 3;
        bus1.fetch_req = 1'b1; bus1.fetch_addr = 5'd2; q1.push_back(e);
        @(negedge clock);
        bus1.fetch_req = 1'b0;
        chk("t1_busy_c1", 32'(bus1.busy), 32'd1);
        chk("t1_valid_c1", 32'(bus1.fetch_valid), 32'd0);
        @(negedge clock);
        chk("t1_busy_c2", 32'(bus1.busy), 32'd1);
        chk("t1_valid_c2", 32'(bus1.fetch_valid), 32'd0);
        @(negedge clock);
        chk("t1_busy_c3", 32'(bus1.busy), 32'd0);
        drain();

        // Held request re-issues every WAIT_CYCLES+2; address change in WAIT ignored.
        @(negedge clock);
        base = cyc;
        bus1.fetch_req = 1'b1; bus1.fetch_addr = 5'd0;
        e.data = 16'h1234; e.due = base + 3; q1.push_back(e);
        @(negedge clock);
        bus1.fetch_addr = 5'd1;
        @(negedge clock);
        @(negedge clock);
        e.data = 16'hABCD; e.due = base + 6; q1.push_back(e);
        @(negedge clock);
        bus1.fetch_req = 1'b0;
        drain();
        repeat (3) @(negedge clock);

        // Load while busy is dropped and flags a sticky error.
        @(negedge clock);
        e.data = 16'h1234; e.due = cyc + 3;
        bus1.fetch_req = 1'b1; bus1.fetch_addr = 5'd0; q1.push_back(e);
        @(negedge clock);
        bus1.fetch_req = 1'b0;
        bus1.load_en = 1'b1; bus1.load_addr = 5'd1; bus1.load_data = 16'hFFFF;
        @(negedge clock);
        bus1.load_en = 1'b0;
        chk("t3_err_set", 32'(bus1.load_err), 32'd1);
        drain();
        repeat (3) @(negedge clock);
        chk("t3_err_sticky", 32'(bus1.load_err), 32'd1);
        do_fetch(1'b0, 5'd1, 16'hABCD);
        drain();

        // Same-edge load and fetch to the same address returns the new word.
        @(negedge clock);
        bus1.load_en = 1'b1; bus1.load_addr = 5'd5; bus1.load_data = 16'h00FF;
        bus1.fetch_req = 1'b1; bus1.fetch_addr = 5'd5;
        e.data = 16'h00FF; e.due = cyc + 3; q1.push_back(e);
        @(negedge clock);
        bus1.load_en = 1'b0; bus1.fetch_req = 1'b0;
        drain();
        chk("t4_err_still", 32'(bus1.load_err), 32'd1);

        // Reset during WAIT aborts the fetch; storage survives.
        @(negedge clock);
        bus1.fetch_req = 1'b1; bus1.fetch_addr = 5'd0;
        @(negedge clock);
        bus1.fetch_req = 1'b0;
        chk("t5_busy_in_wait", 32'(bus1.busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("t5_busy", 32'(bus1.busy), 32'd0);
        chk("t5_valid", 32'(bus1.fetch_valid), 32'd0);
        chk("t5_err", 32'(bus1.load_err), 32'd0);
        chk("t5_data", 32'(bus1.fetch_data), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        do_fetch(1'b0, 5'd0, 16'h1234);
        drain();

        // Zero-wait instance, top address.
        do_load(1'b1, 5'd31, 16'h7777);
        do_fetch(1'b1, 5'd31, 16'h7777);
        drain();
        do_fetch(1'b1, 5'd31, 16'h7777);
        drain();
        do_load(1'b1, 5'd0, 16'h4242);
        do_fetch(1'b1, 5'd0, 16'h4242);
        drain();
`ifdef INSTR_MEM_FETCH_COUNT_EN
        chk("t6_count_w0", 32'(cnt0), 32'd3);
        chk("t6_count_w1", 32'(cnt1), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
